// File: rtl/spi_dma_pkg.sv
// Shared types and constants for the SPI DMA request scheduler.
package spi_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam logic SEL_TX = 1'b0;
  localparam logic SEL_RX = 1'b1;

endpackage

// File: rtl/spi_dma_sched_if.sv
// Handshake bundle between the SPI master, the scheduler and the DMA engine.
interface spi_dma_sched_if #(
  parameter int BCNT_W = 3
);
  logic              enable;
  logic              tx_req;
  logic              tx_ack;
  logic              rx_req;
  logic              rx_ack;
  logic              dma_req;
  logic              dma_sel;
  logic              dma_ack;
  logic              busy;
  logic [BCNT_W-1:0] beat_cnt;
  logic              err;

  // Scheduler side.
  modport master (
    input  enable, tx_req, rx_req, dma_ack,
    output tx_ack, rx_ack, dma_req, dma_sel, busy, beat_cnt, err
  );

  // Environment side (SPI master plus DMA engine).
  modport slave (
    output enable, tx_req, rx_req, dma_ack,
    input  tx_ack, rx_ack, dma_req, dma_sel, busy, beat_cnt, err
  );
endinterface

// File: rtl/spi_dma_rr_arb.sv
// Two-way round-robin winner selection; the pointer moves to the side that did not just finish.
module spi_dma_rr_arb
  import spi_dma_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_tx_req,
  input  logic i_rx_req,
  input  logic i_upd,
  input  logic i_upd_sel,
  output logic o_win_sel,
  output logic o_any
);

  logic r_rr_ptr;

  // Round-robin pointer; 0 favours TX after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= SEL_TX;
    end else if (i_upd) begin
      r_rr_ptr <= ~i_upd_sel;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  // Winner: pointer decides contention, otherwise the lone requester.
  always_comb begin
    o_win_sel = SEL_TX;
    o_any     = i_tx_req | i_rx_req;
    if (i_tx_req && i_rx_req) begin
      o_win_sel = r_rr_ptr;
    end else if (i_rx_req) begin
      o_win_sel = SEL_RX;
    end else begin
      o_win_sel = SEL_TX;
    end
  end

endmodule

// File: rtl/spi_dma_sched.sv
// Shares one DMA request channel between SPI TX and RX handshakes with bounded round-robin bursts.
// Optional watchdog on the DMA beat is built when SPI_DMA_WDOG_EN is defined.
module spi_dma_sched
  import spi_dma_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int BCNT_W    = 3,
  parameter int TIMEOUT   = 256
) (
  input logic           clk,
  input logic           rst,
  spi_dma_sched_if.master bus
);

  localparam logic [BCNT_W-1:0] BURST_MAX = BCNT_W'(BURST_LEN);

  state_e            r_state;
  logic              r_dma_req;
  logic              r_dma_sel;
  logic              r_tx_ack;
  logic              r_rx_ack;
  logic              r_busy;
  logic              r_err;
  logic [BCNT_W-1:0] r_beat_cnt;

  logic w_win_sel;
  logic w_any;
  logic w_same_req;
  logic w_continue;
  logic w_timeout;
  logic w_rr_upd;

  spi_dma_rr_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_tx_req  (bus.tx_req),
    .i_rx_req  (bus.rx_req),
    .i_upd     (w_rr_upd),
    .i_upd_sel (r_dma_sel),
    .o_win_sel (w_win_sel),
    .o_any     (w_any)
  );

`ifdef SPI_DMA_WDOG_EN
  localparam int             WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] r_wdog_cnt;

  // Beat watchdog: counts WAIT cycles, clears whenever WAIT is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog_cnt <= '0;
    end else if ((r_state == WAIT) && !bus.dma_ack && !w_timeout) begin
      r_wdog_cnt <= r_wdog_cnt + WD_W'(1);
    end else begin
      r_wdog_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == WAIT) && !bus.dma_ack && (r_wdog_cnt == WD_LIM);
`else
  assign w_timeout = 1'b0;
`endif

  // Burst continuation test and round-robin pointer update strobe.
  always_comb begin
    w_same_req = (r_dma_sel == SEL_RX) ? bus.rx_req : bus.tx_req;
    w_continue = bus.enable && w_same_req && (r_beat_cnt < BURST_MAX);
    if (r_state == GAP) begin
      w_rr_upd = !w_continue;
    end else begin
      w_rr_upd = w_timeout;
    end
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_dma_req  <= 1'b0;
      r_dma_sel  <= SEL_TX;
      r_tx_ack   <= 1'b0;
      r_rx_ack   <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_tx_ack <= 1'b0;
      r_rx_ack <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.enable && w_any) begin
            r_dma_sel <= w_win_sel;
            r_dma_req <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (bus.dma_ack) begin
            r_dma_req <= 1'b0;
            r_tx_ack  <= (r_dma_sel == SEL_TX);
            r_rx_ack  <= (r_dma_sel == SEL_RX);
            if (r_beat_cnt < BURST_MAX) begin
              r_beat_cnt <= r_beat_cnt + BCNT_W'(1);
            end
            r_state <= ACK;
          end else if (w_timeout) begin
            r_dma_req  <= 1'b0;
            r_err      <= 1'b1;
            r_beat_cnt <= '0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        ACK: begin
          r_state <= GAP;
        end
        GAP: begin
          // Requester had the ACK cycle to drop req; a held req continues the burst.
          if (w_continue) begin
            r_dma_req <= 1'b1;
            r_state   <= WAIT;
          end else begin
            r_beat_cnt <= '0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_dma_req  <= 1'b0;
          r_busy     <= 1'b0;
          r_beat_cnt <= '0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.dma_req  = r_dma_req;
  assign bus.dma_sel  = r_dma_sel;
  assign bus.tx_ack   = r_tx_ack;
  assign bus.rx_ack   = r_rx_ack;
  assign bus.busy     = r_busy;
  assign bus.beat_cnt = r_beat_cnt;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_spi_dma_sched.sv
// Directed self-checking bench for spi_dma_sched (BURST_LEN=4, TIMEOUT=16).
module tb_spi_dma_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  spi_dma_sched_if #(.BCNT_W(3)) bus ();

  spi_dma_sched #(
    .BURST_LEN (4),
    .BCNT_W    (3),
    .TIMEOUT   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.enable  = 1'b0;
    bus.tx_req  = 1'b0;
    bus.rx_req  = 1'b0;
    bus.dma_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Called in the first WAIT cycle of a beat; returns in the cycle after GAP.
  task automatic beat(input string tag, input logic sel, input logic [7:0] cnt);
    logic exp_tx;
    logic exp_rx;
    exp_tx = (sel == 1'b0);
    exp_rx = (sel == 1'b1);
    chk({tag, "_req"}, {7'd0, bus.dma_req}, 8'd1);
    chk({tag, "_sel"}, {7'd0, bus.dma_sel}, {7'd0, sel});
    bus.dma_ack = 1'b1;
    tick();
    bus.dma_ack = 1'b0;
    chk({tag, "_req_drop"}, {7'd0, bus.dma_req}, 8'd0);
    chk({tag, "_txack"}, {7'd0, bus.tx_ack}, {7'd0, exp_tx});
    chk({tag, "_rxack"}, {7'd0, bus.rx_ack}, {7'd0, exp_rx});
    chk({tag, "_cnt"}, {5'd0, bus.beat_cnt}, cnt);
    chk({tag, "_err"}, {7'd0, bus.err}, 8'd0);
    tick();
    chk({tag, "_ack_clr"}, {6'd0, bus.tx_ack, bus.rx_ack}, 8'd0);
    tick();
  endtask

  initial begin
    bus.enable  = 1'b0;
    bus.tx_req  = 1'b0;
    bus.rx_req  = 1'b0;
    bus.dma_ack = 1'b0;
    tick();
    chk("rst_req", {7'd0, bus.dma_req}, 8'd0);
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    chk("rst_acks", {6'd0, bus.tx_ack, bus.rx_ack}, 8'd0);
    chk("rst_cnt", {5'd0, bus.beat_cnt}, 8'd0);
    chk("rst_err", {7'd0, bus.err}, 8'd0);
    do_reset();

    // 1: single TX beat; stray dma_ack in IDLE afterwards is ignored.
    bus.enable = 1'b1;
    bus.tx_req = 1'b1;
    tick();
    chk("t1_busy", {7'd0, bus.busy}, 8'd1);
    bus.dma_ack = 1'b1;
    tick();
    bus.dma_ack = 1'b0;
    bus.tx_req  = 1'b0;
    chk("t1_txack", {7'd0, bus.tx_ack}, 8'd1);
    chk("t1_rxack", {7'd0, bus.rx_ack}, 8'd0);
    chk("t1_cnt", {5'd0, bus.beat_cnt}, 8'd1);
    tick();
    chk("t1_gap_busy", {7'd0, bus.busy}, 8'd1);
    chk("t1_gap_ack", {7'd0, bus.tx_ack}, 8'd0);
    tick();
    chk("t1_idle_busy", {7'd0, bus.busy}, 8'd0);
    chk("t1_idle_cnt", {5'd0, bus.beat_cnt}, 8'd0);
    bus.dma_ack = 1'b1;
    tick();
    bus.dma_ack = 1'b0;
    chk("t1_stray_ack", {6'd0, bus.tx_ack, bus.rx_ack}, 8'd0);
    chk("t1_stray_req", {7'd0, bus.dma_req}, 8'd0);

    // 2: both requesting -> 4 TX beats, 4 RX beats, then TX again.
    do_reset();
    bus.enable = 1'b1;
    bus.tx_req = 1'b1;
    bus.rx_req = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) beat("t2_tx", 1'b0, 8'(i));
    chk("t2_idle1_busy", {7'd0, bus.busy}, 8'd0);
    chk("t2_idle1_req", {7'd0, bus.dma_req}, 8'd0);
    chk("t2_idle1_cnt", {5'd0, bus.beat_cnt}, 8'd0);
    tick();
    for (int i = 1; i <= 4; i++) beat("t2_rx", 1'b1, 8'(i));
    chk("t2_idle2_busy", {7'd0, bus.busy}, 8'd0);
    tick();
    chk("t2_regrant_req", {7'd0, bus.dma_req}, 8'd1);
    chk("t2_regrant_sel", {7'd0, bus.dma_sel}, 8'd0);

    // 3: RX drops req during WAIT; request is not retracted.
    do_reset();
    bus.enable = 1'b1;
    bus.rx_req = 1'b1;
    tick();
    bus.rx_req = 1'b0;
    chk("t3_sel", {7'd0, bus.dma_sel}, 8'd1);
    tick();
    chk("t3_hold1", {7'd0, bus.dma_req}, 8'd1);
    tick();
    chk("t3_hold2", {7'd0, bus.dma_req}, 8'd1);
    bus.dma_ack = 1'b1;
    tick();
    bus.dma_ack = 1'b0;
    chk("t3_rxack", {7'd0, bus.rx_ack}, 8'd1);
    chk("t3_txack", {7'd0, bus.tx_ack}, 8'd0);
    tick();
    tick();
    chk("t3_idle", {7'd0, bus.busy}, 8'd0);

    // 4: enable drops during beat 2.
    do_reset();
    bus.enable = 1'b1;
    bus.tx_req = 1'b1;
    tick();
    beat("t4_b1", 1'b0, 8'd1);
    bus.enable = 1'b0;
    chk("t4_b2_req", {7'd0, bus.dma_req}, 8'd1);
    bus.dma_ack = 1'b1;
    tick();
    bus.dma_ack = 1'b0;
    chk("t4_b2_ack", {7'd0, bus.tx_ack}, 8'd1);
    chk("t4_b2_cnt", {5'd0, bus.beat_cnt}, 8'd2);
    tick();
    tick();
    chk("t4_idle_busy", {7'd0, bus.busy}, 8'd0);
    chk("t4_idle_cnt", {5'd0, bus.beat_cnt}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_grant", {7'd0, bus.dma_req}, 8'd0);
    end
    bus.enable = 1'b1;
    tick();
    chk("t4_regrant", {7'd0, bus.dma_req}, 8'd1);
    chk("t4_regrant_sel", {7'd0, bus.dma_sel}, 8'd0);

    // 5: async reset mid-beat; pointer (now favouring RX) returns to TX.
    beat("t5_b1", 1'b0, 8'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("t5_req", {7'd0, bus.dma_req}, 8'd0);
    chk("t5_busy", {7'd0, bus.busy}, 8'd0);
    chk("t5_cnt", {5'd0, bus.beat_cnt}, 8'd0);
    chk("t5_acks", {6'd0, bus.tx_ack, bus.rx_ack}, 8'd0);
    tick();
    rst = 1'b0;
    bus.rx_req = 1'b1;
    tick();
    chk("t5_ptr_req", {7'd0, bus.dma_req}, 8'd1);
    chk("t5_ptr_sel", {7'd0, bus.dma_sel}, 8'd0);

`ifdef SPI_DMA_WDOG_EN
    // 6: watchdog abort after 16 WAIT cycles.
    do_reset();
    bus.enable = 1'b1;
    bus.tx_req = 1'b1;
    tick();
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("t6_wait_req", {7'd0, bus.dma_req}, 8'd1);
      chk("t6_wait_err", {7'd0, bus.err}, 8'd0);
    end
    tick();
    bus.tx_req = 1'b0;
    chk("t6_drop", {7'd0, bus.dma_req}, 8'd0);
    chk("t6_err", {7'd0, bus.err}, 8'd1);
    chk("t6_noack", {7'd0, bus.tx_ack}, 8'd0);
    chk("t6_busy", {7'd0, bus.busy}, 8'd0);
    tick();
    chk("t6_err_clr", {7'd0, bus.err}, 8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
